cs_y_framer: RTL

- Downstream stage of the CS comparator/selector; consumes its 10-bit Y stream, one sample per clock when y_valid is high.
- Discards the CS warm-up outputs, groups the remaining samples into fixed-length frames, and computes a per-frame sum.
- Buffers samples in a small FIFO and presents them to the next consumer over a valid/ready handshake.
- Reports lost samples, since CS cannot be stalled.

---
 rtl/cs_y_framer.sv | 100 ++++++++++
 1 files changed

// File: rtl/cs_y_framer.sv
// cs_y_framer: drops CS warm-up samples, frames the Y stream with exact per-frame sums,
// and buffers it in a small FIFO behind a valid/ready handshake, counting lost samples.
//   clk, reset                     : rising-edge clock, async active-low reset
//   y_in, y_valid                  : CS sample stream (cannot be stalled)
//   out_data, out_last, out_sum    : FIFO head sample, end-of-frame flag, frame sum (0 unless last)
//   out_valid, out_ready           : FIFO non-empty / consumer accepts head
//   overflow, drop_cnt             : sticky drop flag, saturating dropped-sample count
module cs_y_framer #(
   parameter int DW        = 10,
   parameter int FRAME_LEN = 8,
   parameter int WARMUP    = 8,
   parameter int DEPTH     = 4
) (
   input  logic                              clk,
   input  logic                              reset,
   input  logic [DW-1:0]                     y_in,
   input  logic                              y_valid,
   output logic [DW-1:0]                     out_data,
   output logic                              out_last,
   output logic [DW+$clog2(FRAME_LEN)-1:0]   out_sum,
   output logic                              out_valid,
   input  logic                              out_ready,
   output logic                              overflow,
   output logic [7:0]                        drop_cnt
);
   localparam int SW = DW + $clog2(FRAME_LEN);
   localparam int PW = $clog2(FRAME_LEN);
   localparam int AW = $clog2(DEPTH);
   localparam int WW = WARMUP > 1 ? $clog2(WARMUP) : 1;
   localparam logic [WW-1:0] W_LAST = WW'(WARMUP > 0 ? WARMUP - 1 : 0);
   localparam logic [PW-1:0] P_LAST = PW'(FRAME_LEN - 1);
   localparam logic [AW:0]   FULL   = DEPTH[AW:0];

   typedef enum logic {S_WARMUP, S_RUN} state_t;

   state_t        state;
   logic [WW-1:0] wcnt;
   logic [PW-1:0] pos;
   logic [SW-1:0] acc;
   logic [AW-1:0] wptr, rptr;
   logic [AW:0]   count;
   logic [DW-1:0] mem_data [DEPTH];
   logic          mem_last [DEPTH];
   logic [SW-1:0] mem_sum  [DEPTH];
   logic          full, pop, take, accept, drop, last;
   logic [SW-1:0] sum;

   // A full FIFO still accepts when the head leaves in the same cycle.
   always_comb begin
      full   = count == FULL;
      pop    = out_valid && out_ready;
      take   = state == S_RUN && y_valid;
      accept = take && (!full || out_ready);
      drop   = take && !accept;
      last   = pos == P_LAST;
      sum    = acc + SW'(y_in);
   end

   // Head is gated so an empty FIFO presents zeros rather than stale storage.
   assign out_valid = count != '0;
   assign out_data  = out_valid ? mem_data[rptr] : '0;
   assign out_last  = out_valid ? mem_last[rptr] : 1'b0;
   assign out_sum   = out_valid ? mem_sum[rptr]  : '0;

   always_ff @(posedge clk or negedge reset)
      if (!reset) begin
         state    <= WARMUP == 0 ? S_RUN : S_WARMUP;
         wcnt     <= '0;
         pos      <= '0;
         acc      <= '0;
         wptr     <= '0;
         rptr     <= '0;
         count    <= '0;
         overflow <= 1'b0;
         drop_cnt <= '0;
      end else begin
         if (state == S_WARMUP && y_valid) begin
            wcnt <= wcnt + 1'b1;
            if (wcnt == W_LAST) state <= S_RUN;
         end
         if (accept) begin
            wptr <= wptr + 1'b1;
            pos  <= last ? '0 : pos + 1'b1;
            acc  <= last ? '0 : sum;
         end
         if (pop) rptr <= rptr + 1'b1;
         count <= count + {{AW{1'b0}}, accept} - {{AW{1'b0}}, pop};
         if (drop) begin
            overflow <= 1'b1;
            if (drop_cnt != 8'hFF) drop_cnt <= drop_cnt + 1'b1;
         end
      end

   always_ff @(posedge clk)
      if (accept) begin
         mem_data[wptr] <= y_in;
         mem_last[wptr] <= last;
         mem_sum[wptr]  <= last ? sum : '0;
      end
endmodule
